parity_rr_ctrl: RTL and testbench

Round-robin controller that shares one reduction-XOR (parity) unit between NREQ requesters. Each requester streams a burst of WIDTH-bit words. The block grants one requester at a time and accumulates the running parity of every accepted beat. It then returns a single parity result tagged with the requester id. It sits in front of the unary-XOR datapath in the parity checking path and owns all sequencing and arbitration for it.

---
 rtl/parity_rr_ctrl.sv | 147 ++++++++++++++
 tb/tb_parity_rr_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rr_ctrl.sv
`default_nettype none
// ============================================================================
// parity_rr_ctrl : round-robin arbiter sharing one parity reducer among NREQ
//                  burst requesters, returning one id-tagged parity per burst.
// Revision: 1.0
// ============================================================================
module parity_rr_ctrl #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 4,
   parameter int IDW      = 2,
   parameter int MAXBEATS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic                    res_valid,
   output logic                    res_parity,
   output logic [IDW-1:0]          res_id,
   output logic                    res_ovf,
   input  logic                    res_ready,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0]     c_maxbeats  = 8'(MAXBEATS);
   localparam logic [IDW-1:0] c_last_idx  = IDW'(NREQ - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_gnt;
   logic [IDW-1:0]   r_last_gnt;
   logic             r_acc;
   logic [7:0]       r_cnt;
   logic             r_res_parity;
   logic [IDW-1:0]   r_res_id;
   logic             r_res_ovf;

   logic [WIDTH-1:0] w_words [NREQ];
   logic [IDW-1:0]   w_cand;
   logic [IDW-1:0]   w_sel;
   logic             w_any;
   logic             w_beat;
   logic             w_beat_par;
   logic             w_beat_last;
   logic             w_at_limit;
   logic             w_term;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_words[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Walk the ring starting just after the previous winner; first hit wins.
   always_comb begin
      w_any  = 1'b0;
      w_sel  = r_last_gnt;
      w_cand = r_last_gnt;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = (w_cand == c_last_idx) ? '0 : w_cand + 1'b1;
         if (!w_any && req[w_cand]) begin
            w_any = 1'b1;
            w_sel = w_cand;
         end
      end
   end

   assign w_beat      = req[r_gnt];
   assign w_beat_par  = ^w_words[r_gnt];
   assign w_beat_last = req_last[r_gnt];
   assign w_at_limit  = (r_cnt + 8'd1) == c_maxbeats;
   assign w_term      = w_beat_last | w_at_limit;

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         IDLE: begin
            if (w_any) w_state_nxt = BUSY;
         end
         BUSY: begin
            req_ready[r_gnt] = 1'b1;
            if (w_beat && w_term) w_state_nxt = DONE;
         end
         DONE: begin
            if (res_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_gnt        <= '0;
         r_last_gnt   <= c_last_idx;
         r_acc        <= 1'b0;
         r_cnt        <= '0;
         r_res_parity <= 1'b0;
         r_res_id     <= '0;
         r_res_ovf    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt <= w_sel;
                  r_acc <= 1'b0;
                  r_cnt <= '0;
               end
            end
            BUSY: begin
               if (w_beat) begin
                  r_acc <= r_acc ^ w_beat_par;
                  r_cnt <= r_cnt + 8'd1;
                  if (w_term) begin
                     r_res_parity <= r_acc ^ w_beat_par;
                     r_res_id     <= r_gnt;
                     // A last flag on the limit beat is a clean end, not an overflow.
                     r_res_ovf    <= w_at_limit & ~w_beat_last;
                  end
               end
            end
            DONE: begin
               if (res_ready) r_last_gnt <= r_gnt;
            end
            default: ;
         endcase
      end
   end

   assign res_valid  = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign res_parity = r_res_parity;
   assign res_id     = r_res_id;
   assign res_ovf    = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_parity_rr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_parity_rr_ctrl : directed bench with a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_parity_rr_ctrl;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 4;
   localparam int IDW      = 2;
   localparam int MAXBEATS = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic                  res_parity;
   logic [IDW-1:0]        res_id;
   logic                  res_ovf;
   logic                  res_ready;
   logic                  busy;

   int n_vec = 0;
   int n_err = 0;

   parity_rr_ctrl #(
      .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .MAXBEATS(MAXBEATS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
      .res_parity(res_parity), .res_id(res_id), .res_ovf(res_ovf),
      .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the unit, what has been folded in, pending result.
   int m_owner = -1;
   int m_last  = NREQ - 1;
   int m_cnt   = 0;
   int m_id    = 0;
   bit m_acc   = 1'b0;
   bit m_have  = 1'b0;
   bit m_par   = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_on    = 1'b0;

   always @(posedge clk) begin
      logic [WIDTH-1:0] word;
      bit               p;
      bit               lst;
      int               cand;
      if (!rst_n) begin
         m_owner = -1; m_have = 1'b0; m_last = NREQ - 1;
         m_par = 1'b0; m_id = 0; m_ovf = 1'b0; m_on = 1'b1;
      end else if (m_have) begin
         if (res_ready) begin
            m_last = m_id;
            m_have = 1'b0;
         end
      end else if (m_owner >= 0) begin
         if (((req >> m_owner) & 1) != 0) begin
            word = WIDTH'(req_data >> (m_owner * WIDTH));
            p    = m_acc ^ (^word);
            lst  = ((req_last >> m_owner) & 1) != 0;
            m_cnt++;
            if (lst || m_cnt == MAXBEATS) begin
               m_par = p; m_id = m_owner; m_ovf = !lst;
               m_have = 1'b1; m_owner = -1;
            end else begin
               m_acc = p;
            end
         end
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = (m_last + k) % NREQ;
            if (m_owner < 0 && ((req >> cand) & 1) != 0) m_owner = cand;
         end
         m_acc = 1'b0;
         m_cnt = 0;
      end
   end

   always @(posedge clk) begin
      logic [NREQ-1:0] exp_ready;
      #1;
      if (m_on) begin
         exp_ready = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
         chk("model req_ready", 32'(req_ready), 32'(exp_ready));
         chk("model res_valid", 32'(res_valid), 32'(m_have));
         chk("model busy", 32'(busy), 32'(m_have || m_owner >= 0));
         if (m_have) begin
            chk("model res_parity", 32'(res_parity), 32'(m_par));
            chk("model res_id", 32'(res_id), 32'(m_id));
            chk("model res_ovf", 32'(res_ovf), 32'(m_ovf));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_id  [5] = '{0, 1, 2, 3, 0};
      int exp_par [5] = '{1, 0, 1, 0, 1};
      int got;
      int prev;
      rst_n = 1'b0; req = '0; req_data = '0; req_last = '0; res_ready = 1'b1;
      tick(); tick();
      chk("reset busy", 32'(busy), 0);
      chk("reset res_valid", 32'(res_valid), 0);
      chk("reset req_ready", 32'(req_ready), 0);
      chk("reset res_parity", 32'(res_parity), 0);
      chk("reset res_id", 32'(res_id), 0);
      chk("reset res_ovf", 32'(res_ovf), 0);
      rst_n = 1'b1;
      tick();

      // Single beat from requester 0
      req = 4'b0001; req_data = 16'h0001; req_last = 4'b0001;
      tick();
      chk("single req_ready", 32'(req_ready), 32'h1);
      tick();
      chk("single res_valid", 32'(res_valid), 1);
      chk("single res_parity", 32'(res_parity), 1);
      chk("single res_id", 32'(res_id), 0);
      chk("single res_ovf", 32'(res_ovf), 0);
      req = '0; req_last = '0;
      tick();
      chk("single back to idle", 32'(busy), 0);

      // Requester 2, three beats with a bubble
      req = 4'b0100; req_data[8 +: 4] = 4'b0011;
      tick();
      chk("burst req_ready", 32'(req_ready), 32'h4);
      tick();
      req = '0;
      tick();
      chk("bubble no result", 32'(res_valid), 0);
      req = 4'b0100; req_data[8 +: 4] = 4'b0001;
      tick();
      req_data[8 +: 4] = 4'b0111; req_last = 4'b0100;
      tick();
      chk("burst res_valid", 32'(res_valid), 1);
      chk("burst res_parity", 32'(res_parity), 0);
      chk("burst res_id", 32'(res_id), 2);
      req = '0; req_last = '0;
      tick();
      req = 4'b0100; req_data[8 +: 4] = 4'b0000; req_last = 4'b0100;
      tick(); tick();
      chk("zero word parity", 32'(res_parity), 0);
      chk("zero word id", 32'(res_id), 2);
      req = '0; req_last = '0;
      tick();

      // Round robin: all four hold single-beat bursts
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b1111; req_last = 4'b1111; req_data = 16'hF731;
      got = 0; prev = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         tick();
         if (res_valid) begin
            chk("rr res_id", 32'(res_id), 32'(exp_id[got]));
            chk("rr res_parity", 32'(res_parity), 32'(exp_par[got]));
            if (got > 0) chk("rr spacing", 32'(cyc - prev), 3);
            prev = cyc;
            got++;
            if (got == 5) begin
               req = '0; req_last = '0;
               break;
            end
         end
      end
      chk("rr result count", 32'(got), 5);
      tick();

      // Backpressure on requester 3's result
      res_ready = 1'b0;
      req = 4'b1000; req_data = 16'hB000; req_last = 4'b1000;
      tick(); tick();
      chk("bp res_valid", 32'(res_valid), 1);
      req = 4'b0001; req_data = 16'h0001; req_last = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         chk("bp hold valid", 32'(res_valid), 1);
         chk("bp hold parity", 32'(res_parity), 1);
         chk("bp hold id", 32'(res_id), 3);
         chk("bp req_ready", 32'(req_ready), 0);
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("bp turnaround idle", 32'(busy), 0);
      tick();
      chk("bp next grant", 32'(req_ready), 32'h1);
      tick();
      chk("bp next id", 32'(res_id), 0);
      req = '0; req_last = '0;
      tick();

      // Overflow: 8 beats, last never asserted
      req = 4'b0010; req_data = 16'h0080; req_last = 4'b0000;
      tick();
      chk("ovf grant", 32'(req_ready), 32'h2);
      for (int i = 0; i < MAXBEATS; i++) tick();
      chk("ovf res_valid", 32'(res_valid), 1);
      chk("ovf res_ovf", 32'(res_ovf), 1);
      chk("ovf res_parity", 32'(res_parity), 0);
      chk("ovf res_id", 32'(res_id), 1);
      chk("ovf no 9th beat", 32'(req_ready), 0);
      req = '0;
      tick();
      req = 4'b0010;
      tick();
      for (int i = 0; i < MAXBEATS - 1; i++) tick();
      req_last = 4'b0010;
      tick();
      chk("last at limit valid", 32'(res_valid), 1);
      chk("last at limit ovf", 32'(res_ovf), 0);
      req = '0; req_last = '0;
      tick();

      // Reset in the middle of a burst
      req = 4'b1000; req_data = 16'hB000;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("midrst busy", 32'(busy), 0);
      chk("midrst res_valid", 32'(res_valid), 0);
      chk("midrst req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      req = 4'b1001; req_data = 16'hB001; req_last = 4'b1001;
      tick();
      chk("midrst grant 0", 32'(req_ready), 32'h1);
      tick();
      chk("midrst res_valid", 32'(res_valid), 1);
      chk("midrst res_id", 32'(res_id), 0);
      chk("midrst res_parity", 32'(res_parity), 1);
      req = '0; req_last = '0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
